// File: rtl/freq_meas_pkg.sv
// Types and default constants shared by the PPS-gated frequency counter and phase_meas.
package freq_meas_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MEAS = 1'b1
   } meas_state_e;

   localparam int NOMINAL_DFLT = 100_000_000;
   localparam int TIMEOUT_DFLT = 110_000_000;

endpackage

// File: rtl/pps_sync_edge.sv
// Three-flop synchroniser for an asynchronous PPS input with a one-cycle rising-edge pulse.
module pps_sync_edge (
   input  logic i_clk,
   input  logic i_res_n,
   input  logic i_async,
   output logic o_edge
);

   logic [2:0] sync_q;

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], i_async};
      end
   end

   // stage 0 may be metastable; the edge is taken between stages 1 and 2
   assign o_edge = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_counter_gated.sv
// PPS-gated reference-clock frequency counter with programmable gate length,
// signed deviation from nominal, and PPS-loss timeout with automatic re-arm.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | armed; next synchronised PPS edge opens a gate (no result)
// ST_MEAS | gate running; counting cycles and PPS periods
module freq_counter_gated
   import freq_meas_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int GSEL_W  = 4,
   parameter int NOMINAL = NOMINAL_DFLT,
   parameter int TIMEOUT = TIMEOUT_DFLT
) (
   input  logic              i_clk,
   input  logic              i_res_n,
   input  logic              i_pps,
   input  logic              i_clr,
   input  logic [GSEL_W-1:0] i_gate_sel,
   output logic [CNT_W-1:0]  o_freq,
   output logic [CNT_W-1:0]  o_dev,
   output logic [GSEL_W:0]   o_gate_len,
   output logic              o_valid,
   output logic              o_sat,
   output logic              o_pps_lost
);

   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int LEN_W = GSEL_W + 1;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] NOM_C   = CNT_W'(NOMINAL);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0]  TO_END  = TO_W'(TIMEOUT);

   logic              pps_edge;
   meas_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              sat_q;
   logic [LEN_W-1:0]  per_q;
   logic [LEN_W-1:0]  glen_q;
   logic [CNT_W-1:0]  exp_q;
   logic [TO_W-1:0]   to_q;
   logic              lost_q;
   logic [CNT_W-1:0]  freq_q;
   logic [CNT_W-1:0]  dev_q;
   logic [LEN_W-1:0]  olen_q;
   logic              valid_q;
   logic              osat_q;

   logic              cnt_full;
   logic              gate_done;
   logic [CNT_W-1:0]  freq_close;
   logic [CNT_W-1:0]  exp_close;
   logic [LEN_W-1:0]  len_next;

   pps_sync_edge u_pps_sync (
      .i_clk   (i_clk),
      .i_res_n (i_res_n),
      .i_async (i_pps),
      .o_edge  (pps_edge)
   );

   // the closing edge itself is the last counted cycle, hence the +1
   assign cnt_full   = (cnt_q == CNT_MAX);
   assign freq_close = cnt_full ? CNT_MAX : cnt_q + CNT_W'(1);
   assign exp_close  = exp_q + NOM_C;
   assign gate_done  = ((per_q + LEN_W'(1)) == glen_q);
   assign len_next   = LEN_W'(i_gate_sel) + LEN_W'(1);

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         per_q   <= '0;
         glen_q  <= LEN_W'(1);
         exp_q   <= '0;
         to_q    <= '0;
         lost_q  <= 1'b0;
         freq_q  <= '0;
         dev_q   <= '0;
         olen_q  <= LEN_W'(1);
         valid_q <= 1'b0;
         osat_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (i_clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            per_q   <= '0;
            exp_q   <= '0;
            to_q    <= '0;
            lost_q  <= 1'b0;
         end else if (pps_edge) begin
            to_q   <= '0;
            lost_q <= 1'b0;
            if (state_q == ST_MEAS && gate_done) begin
               freq_q  <= freq_close;
               dev_q   <= freq_close - exp_close;
               olen_q  <= glen_q;
               osat_q  <= sat_q | cnt_full;
               valid_q <= 1'b1;
            end
            // gate start: from IDLE, or back-to-back after a close
            if (state_q == ST_IDLE || gate_done) begin
               state_q <= ST_MEAS;
               cnt_q   <= '0;
               sat_q   <= 1'b0;
               per_q   <= '0;
               exp_q   <= '0;
               glen_q  <= len_next;
            end else begin
               per_q <= per_q + LEN_W'(1);
               exp_q <= exp_close;
               if (cnt_full) begin
                  sat_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end else begin
            if (to_q != TO_END) begin
               to_q <= to_q + TO_W'(1);
            end
            if (to_q == TO_LAST) begin
               lost_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            if (state_q == ST_MEAS) begin
               if (cnt_full) begin
                  sat_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end
      end
   end

   assign o_freq     = freq_q;
   assign o_dev      = dev_q;
   assign o_gate_len = olen_q;
   assign o_valid    = valid_q;
   assign o_sat      = osat_q;
   assign o_pps_lost = lost_q;

endmodule

// File: tb/tb_freq_counter_gated.sv
// Randomised and directed bench for freq_counter_gated against an event-time reference model.
module tb_freq_counter_gated;

   localparam int NOM = 1000;
   localparam int TO  = 1500;
   localparam int GW  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pps = 1'b0;
   logic          clr = 1'b0;
   logic [GW-1:0] gsel = '0;

   logic [15:0] f16, d16;
   logic [GW:0] len16;
   logic        v16, s16, l16;
   logic [11:0] f12, d12;
   logic [GW:0] len12;
   logic        v12, s12, l12;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   freq_counter_gated #(.CNT_W(16), .GSEL_W(GW), .NOMINAL(NOM), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_res_n(rst_n), .i_pps(pps), .i_clr(clr), .i_gate_sel(gsel),
      .o_freq(f16), .o_dev(d16), .o_gate_len(len16), .o_valid(v16), .o_sat(s16), .o_pps_lost(l16)
   );

   freq_counter_gated #(.CNT_W(12), .GSEL_W(GW), .NOMINAL(NOM), .TIMEOUT(TO)) dut12 (
      .i_clk(clk), .i_res_n(rst_n), .i_pps(pps), .i_clr(clr), .i_gate_sel(gsel),
      .o_freq(f12), .o_dev(d12), .o_gate_len(len12), .o_valid(v12), .o_sat(s12), .o_pps_lost(l12)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: events in absolute cycle numbers; results from time differences.
   longint m = 0;
   bit     h0, h1, h2, e;
   bit     armed, lost_e, valid_e, has_res;
   longint t_open, t_last, raw_e;
   int     n_per, glen, len_e;

   function automatic longint mx_of(input int w);
      return (longint'(1) << w) - 1;
   endfunction

   function automatic longint exp_freq(input int w);
      if (!has_res) return 0;
      return (raw_e > mx_of(w)) ? mx_of(w) : raw_e;
   endfunction

   function automatic longint exp_dev(input int w);
      if (!has_res) return 0;
      return (exp_freq(w) - longint'(NOM) * len_e) & mx_of(w);
   endfunction

   function automatic longint exp_sat(input int w);
      return (has_res && raw_e > mx_of(w)) ? 1 : 0;
   endfunction

   function automatic longint exp_len();
      return has_res ? len_e : 1;
   endfunction

   always @(posedge clk) begin
      m++;
      if (!rst_n) begin
         h0 = 0; h1 = 0; h2 = 0;
         armed = 0; lost_e = 0; valid_e = 0; has_res = 0;
         t_last = m;
      end else begin
         e  = h1 & ~h2;
         h2 = h1; h1 = h0; h0 = pps;
         valid_e = 0;
         if (clr) begin
            armed = 0; lost_e = 0; t_last = m;
         end else if (e) begin
            t_last = m; lost_e = 0;
            if (armed) begin
               n_per++;
               if (n_per == glen) begin
                  valid_e = 1; has_res = 1; raw_e = m - t_open; len_e = glen;
               end
            end
            if (!armed || valid_e) begin
               armed = 1; t_open = m; n_per = 0; glen = int'(gsel) + 1;
            end
         end else if (m - t_last == TO) begin
            lost_e = 1; armed = 0;
         end
      end
      #1;
      chk("valid16", v16, valid_e);
      chk("lost16",  l16, lost_e);
      chk("freq16",  f16, exp_freq(16));
      chk("dev16",   d16, exp_dev(16));
      chk("len16",   len16, exp_len());
      chk("sat16",   s16, exp_sat(16));
      chk("valid12", v12, valid_e);
      chk("lost12",  l12, lost_e);
      chk("freq12",  f12, exp_freq(12));
      chk("dev12",   d12, exp_dev(12));
      chk("len12",   len12, exp_len());
      chk("sat12",   s12, exp_sat(12));
   end

   // result capture for the literal expectations
   int          vcnt = 0;
   bit          lost_seen = 0;
   logic [15:0] lf, ld;
   logic [GW:0] ll;
   logic [11:0] lf12;
   logic        ls12;

   always @(negedge clk) begin
      if (v16) begin
         vcnt++; lf = f16; ld = d16; ll = len16;
      end
      if (v12) begin
         lf12 = f12; ls12 = s12;
      end
      if (l16) lost_seen = 1;
   end

   task automatic period(input int p, input int hi);
      pps = 1'b1;
      repeat (hi) @(negedge clk);
      pps = 1'b0;
      repeat (p - hi) @(negedge clk);
   endtask

   int vc0, vc1, rp, rhi;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_freq", f16, 0);
      chk("rst_dev", d16, 0);
      chk("rst_len", len16, 1);
      chk("rst_valid", v16, 0);
      chk("rst_lost", l16, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: nominal period, 1-period gate
      gsel = 4'd0;
      vc0 = vcnt;
      period(1000, 5);
      chk("t1_arm_novalid", vcnt, vc0);
      repeat (3) period(1000, 5);
      chk("t1_count", vcnt, vc0 + 3);
      chk("t1_freq", lf, 1000);
      chk("t1_dev", ld, 0);
      chk("t1_len", ll, 1);

      // 2: 4-period gate at 1002
      gsel = 4'd3;
      repeat (9) period(1002, 5);
      chk("t2_freq", lf, 4008);
      chk("t2_dev", ld, 8);
      chk("t2_len", ll, 4);

      // 3: 998 period, gate select changed mid-gate
      gsel = 4'd0;
      repeat (4) period(998, 5);
      pps = 1'b1;
      repeat (5) @(negedge clk);
      pps = 1'b0;
      repeat (400) @(negedge clk);
      gsel = 4'd2;
      repeat (593) @(negedge clk);
      chk("t3_freq1", lf, 998);
      chk("t3_dev1", ld, 16'hFFFE);
      period(998, 5);
      chk("t3_freq1b", lf, 998);
      chk("t3_len1b", ll, 1);
      repeat (3) period(998, 5);
      chk("t3_freq3", lf, 2994);
      chk("t3_dev3", ld, 16'hFFFA);
      chk("t3_len3", ll, 3);

      // 4: PPS loss and recovery
      gsel = 4'd0;
      vc0 = vcnt;
      repeat (400) @(negedge clk);
      chk("t4_not_lost_yet", l16, 0);
      repeat (200) @(negedge clk);
      chk("t4_lost", l16, 1);
      chk("t4_no_valid", vcnt, vc0);
      period(1000, 5);
      chk("t4_lost_cleared", l16, 0);
      chk("t4_arm_only", vcnt, vc0);
      period(1000, 5);
      chk("t4_valid", vcnt, vc0 + 1);
      chk("t4_freq", lf, 1000);

      // 5: 8-period gate saturates the 12-bit counter
      gsel = 4'd7;
      repeat (9) period(1000, 5);
      chk("t5_freq12", lf12, 4095);
      chk("t5_sat12", ls12, 1);
      chk("t5_freq16", lf, 8000);
      chk("t5_len16", ll, 8);

      // 6: clear, clear on a closing edge, reset mid-gate
      gsel = 4'd0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (10) @(negedge clk);
      vc0 = vcnt;
      period(1000, 5);
      pps = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (2) @(negedge clk);
      pps = 1'b0;
      repeat (995) @(negedge clk);
      chk("t6_clr_edge_novalid", vcnt, vc0);
      period(1000, 5);
      chk("t6_rearm_only", vcnt, vc0);
      period(1000, 5);
      chk("t6_valid", vcnt, vc0 + 1);
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_rst_freq", f16, 0);
      chk("t6_rst_dev", d16, 0);
      chk("t6_rst_len", len16, 1);
      chk("t6_rst_sat", s16, 0);
      chk("t6_rst_lost", l16, 0);
      rst_n = 1'b1;
      vc0 = vcnt;
      period(1000, 5);
      chk("t6_post_rst_arm", vcnt, vc0);
      period(1000, 5);
      chk("t6_post_rst_freq", lf, 1000);

      // 7: timeout boundary; an edge exactly at TIMEOUT wins
      lost_seen = 0;
      repeat (2) period(1500, 5);
      chk("t7_freq1500", lf, 1500);
      chk("t7_dev1500", ld, 500);
      chk("t7_no_loss", lost_seen, 0);
      period(1501, 5);
      vc1 = vcnt;
      period(1501, 5);
      chk("t7_discarded", vcnt, vc1);
      chk("t7_loss_seen", lost_seen, 1);
      chk("t7_lost_cleared", l16, 0);

      // randomised periods, pulse widths, gate selects and clears
      for (int i = 0; i < 25; i++) begin
         rp  = 990 + int'($urandom_range(0, 20));
         rhi = 1 + int'($urandom_range(0, 19));
         if ($urandom_range(0, 3) == 0) gsel = GW'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            pps = 1'b1;
            repeat (rhi) @(negedge clk);
            pps = 1'b0;
            repeat (300) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            repeat (rp - rhi - 301) @(negedge clk);
         end else begin
            period(rp, rhi);
         end
      end
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/freq_counter_gated.md
# freq_counter_gated

Parametrised, PPS-gated reference-clock frequency counter for the phase-monitor FPGA. It counts `i_clk` cycles over a gate of 1..2^GSEL_W PPS periods and reports the count and its signed deviation from nominal, with a one-cycle result strobe. It detects PPS loss by timeout and re-arms automatically. It replaces the fixed 1-second, 28-bit counter and sits between the GPS PPS input and the phase-measurement/readout logic.

## Interface
- CNT_W, 32: width of the cycle counter, o_freq and o_dev.
- GSEL_W, 4: width of gate select; gate length = i_gate_sel+1 PPS periods.
- NOMINAL, 100_000_000: expected cycles per PPS period.
- TIMEOUT, 110_000_000: cycles without a PPS edge before loss is declared; must be > NOMINAL.

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_res_n  in  1  reset; asynchronous, active-low.
- i_pps  in  1  asynchronous 1PPS from GPS.
- i_clr  in  1  synchronous clear/re-arm; one-cycle pulse.
- i_gate_sel  in  GSEL_W  requested gate length minus one; sampled at each gate start.
- o_freq  out  CNT_W  cycles counted over the last completed gate.
- o_dev  out  CNT_W  signed (o_freq − NOMINAL×gate_len) for the last gate.
- o_gate_len  out  GSEL_W+1  gate length used by the last result (1..2^GSEL_W).
- o_valid  out  1  one-cycle strobe; o_freq/o_dev/o_gate_len updated this cycle.
- o_sat  out  1  last result saturated at 2^CNT_W−1.
- o_pps_lost  out  1  level; PPS timeout active.

## Operation
- PPS path: 3-FF synchroniser; edge = stage1 high and stage2 low.
- States: IDLE (armed, waiting for the first edge) and MEAS (gate running).
- IDLE + edge:
  - clear cycle and period counters;
  - latch gate_len = i_gate_sel+1;
  - clear the expected accumulator;
  - go to MEAS.
- MEAS:
  - The cycle counter increments every non-edge cycle and saturates at all-ones; the saturation sets an internal sat bit.
  - On each edge, the period counter increments and the expected accumulator adds NOMINAL.
  - On the edge that completes gate_len periods:
    - o_freq = cnt+1;
    - o_dev = (cnt+1) − expected, where expected already includes this period;
    - o_gate_len = gate_len; o_sat = sat (forced 1 if the cycle counter is saturated);
    - o_valid = 1.
    - A new gate starts on the same edge: counters clear, i_gate_sel is re-latched, and the FSM stays in MEAS. There is no dead time.
- Timeout: a since-edge counter clears on every edge and increments otherwise. When it reaches TIMEOUT:
  - o_pps_lost = 1;
  - the FSM goes to IDLE;
  - the gate in progress is discarded (no o_valid).
- The next edge clears o_pps_lost and arms the gate (IDLE rule). It does not produce a result.
- i_clr: FSM goes to IDLE, counters clear, and o_pps_lost clears. Result outputs hold their values.
- Arithmetic: the expected accumulator is CNT_W bits, wrapping modulo 2^CNT_W. o_dev is a two's-complement difference modulo 2^CNT_W.

## Timing
- Reset values: o_freq=0, o_dev=0, o_gate_len=1, o_valid=0, o_sat=0, o_pps_lost=0, FSM=IDLE.
- Latency: i_pps first sampled high at edge E0 → o_valid high after E2, for exactly one cycle.
- Between valids: gate_len×period cycles. o_freq equals the exact number of i_clk cycles between the gate's opening and closing synchronised edges.
- Simultaneous events:
  - i_clr + edge: i_clr wins; the edge is ignored.
  - Edge in the cycle the since-edge counter would reach TIMEOUT: the edge wins; no loss.
  - i_gate_sel change mid-gate: takes effect at the next gate start only.
- Reset asserted mid-gate: all state is cleared asynchronously. The first edge after release arms the gate and produces no result.

## Structure
- Shared package freq_meas_pkg holds the FSM state encoding (IDLE=1'b0, MEAS=1'b1) and the default NOMINAL/TIMEOUT constants, for reuse by phase_meas.
- Sub-module pps_sync_edge contains the 3-FF synchroniser and the one-cycle rising-edge pulse. It is shared with other PPS consumers.
- The result registers are updated only on the close strobe. Downstream blocks latch them on o_valid, so no CDC logic lives here.

## Test plan
Parameters: NOMINAL=1000, TIMEOUT=1500, CNT_W=16.

1. PPS every 1000 cycles, gate_sel=0 → first edge arms. Every following edge gives o_valid with o_freq=1000, o_dev=0, o_gate_len=1.
2. gate_sel=3, PPS every 1002 cycles → o_valid every 4008 cycles, o_freq=4008, o_dev=+8, o_gate_len=4.
3. PPS every 998 cycles, then gate_sel changed 0→2 mid-gate → one more 1-period result (o_freq=998, o_dev=−2), then 3-period results (o_freq=2994, o_dev=−6).
4. PPS stopped after a valid → o_pps_lost rises 1500 cycles after the last edge, with no o_valid. The next edge clears o_pps_lost; the following edge at 1000 cycles gives o_freq=1000.
5. CNT_W=12, gate_sel=7, PPS 1000 cycles → the count saturates; o_sat=1, o_freq=4095.
6. i_clr coincident with a closing edge, and i_res_n pulsed mid-gate → no o_valid on that edge. After reset all outputs return to their reset values, and the first subsequent edge only arms.
